// File: rtl/crc_decoder_pkg.sv
// Shared constants, FSM state encoding and the single-bit CRC-8 shift step
// used by the CRC-8 decoder (and the matching encoder).
package crc_pkg;

    localparam logic [7:0] CRC_POLY    = 8'h07;
    localparam logic [7:0] CRC_INIT    = 8'h00;
    localparam int         FRAME_BYTES = 4;
    localparam int         CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2,
        ST_OUT  = 2'd3
    } crc_state_e;

    // One MSB-first shift of the CRC register with conditional polynomial fold.
    function automatic logic [7:0] crc8_shift(input logic [7:0] crc_v);
        logic [7:0] res_v;
        if (crc_v[7]) begin
            res_v = {crc_v[6:0], 1'b0} ^ CRC_POLY;
        end else begin
            res_v = {crc_v[6:0], 1'b0};
        end
        return res_v;
    endfunction

endpackage

// File: rtl/crc_decoder_if.sv
// Byte-stream bus of the CRC decoder: upstream byte input with back-pressure
// and the downstream payload output with frame markers and CRC status.
interface crc_decoder_if;

    logic       pushin;
    logic       startin;
    logic [7:0] datain;
    logic       ready;
    logic       pushout;
    logic       startout;
    logic       endout;
    logic [7:0] dataout;
    logic       crcerr;

    modport master (
        output pushin, startin, datain,
        input  ready, pushout, startout, endout, dataout, crcerr
    );

    modport slave (
        input  pushin, startin, datain,
        output ready, pushout, startout, endout, dataout, crcerr
    );

endinterface

// File: rtl/crc8_update.sv
// Combinational CRC-8 byte update: folds one byte, MSB first, into a running
// CRC value. Shared between the encoder and decoder sides.
module crc8_update
    import crc_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_s;

    // XOR the byte into the register, then run eight polynomial shift steps.
    always_comb begin
        crc_s = crc_in ^ byte_in;
        for (int i = 0; i < 8; i++) begin
            crc_s = crc8_shift(crc_s);
        end
        crc_out = crc_s;
    end

endmodule

// File: rtl/crc_decoder.sv
// CRC-8 frame decoder: collects 4 payload bytes plus a CRC byte, checks the
// CRC and forwards the payload on 4 consecutive cycles with start/end markers
// and a CRC error flag on the last byte. Upstream is stalled while forwarding.
module crc_decoder
    import crc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    crc_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_IN_IDX  = CNT_W'(FRAME_BYTES - 1);
    localparam logic [1:0]       LAST_OUT_IDX = 2'(FRAME_BYTES - 1);

    crc_state_e       state_r;
    crc_state_e       state_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [7:0]       crc_r;
    logic [7:0]       crc_nxt_s;
    logic             err_r;
    logic             err_nxt_s;
    logic [1:0]       out_cnt_r;
    logic [1:0]       out_cnt_nxt_s;
    logic [7:0]       buf_r [FRAME_BYTES];
    logic             buf_we_s;
    logic [1:0]       buf_idx_s;

    logic             accept_s;
    logic [7:0]       crc_seed_s;
    logic [7:0]       crc_upd_s;

    logic             ready_r;
    logic             pushout_r;
    logic             startout_r;
    logic             endout_r;
    logic             crcerr_r;
    logic [7:0]       dataout_r;
    logic             ready_nxt_s;
    logic             pushout_nxt_s;
    logic             startout_nxt_s;
    logic             endout_nxt_s;
    logic             crcerr_nxt_s;
    logic [7:0]       dataout_nxt_s;

    // A start byte always seeds the CRC from init, as does any byte seen in IDLE.
    always_comb begin
        if ((state_r == ST_IDLE) || bus.startin) begin
            crc_seed_s = CRC_INIT;
        end else begin
            crc_seed_s = crc_r;
        end
    end

    crc8_update u_crc8_update (
        .crc_in  (crc_seed_s),
        .byte_in (bus.datain),
        .crc_out (crc_upd_s)
    );

    // Next-state, datapath-update and output-next decode for the frame FSM.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        crc_nxt_s      = crc_r;
        err_nxt_s      = err_r;
        out_cnt_nxt_s  = out_cnt_r;
        buf_we_s       = 1'b0;
        buf_idx_s      = 2'd0;
        pushout_nxt_s  = 1'b0;
        startout_nxt_s = 1'b0;
        endout_nxt_s   = 1'b0;
        crcerr_nxt_s   = 1'b0;
        dataout_nxt_s  = dataout_r;
        accept_s       = bus.pushin & ready_r;

        case (state_r)
            ST_IDLE: begin
                if (accept_s && bus.startin) begin
                    buf_we_s    = 1'b1;
                    buf_idx_s   = 2'd0;
                    crc_nxt_s   = crc_upd_s;
                    count_nxt_s = CNT_W'(1);
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (accept_s && bus.startin) begin
                    buf_we_s    = 1'b1;
                    buf_idx_s   = 2'd0;
                    crc_nxt_s   = crc_upd_s;
                    count_nxt_s = CNT_W'(1);
                    state_nxt_s = ST_DATA;
                end else if (accept_s) begin
                    buf_we_s    = 1'b1;
                    buf_idx_s   = count_r[1:0];
                    crc_nxt_s   = crc_upd_s;
                    count_nxt_s = count_r + CNT_W'(1);
                    if (count_r == LAST_IN_IDX) begin
                        state_nxt_s = ST_CHK;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept_s && bus.startin) begin
                    buf_we_s    = 1'b1;
                    buf_idx_s   = 2'd0;
                    crc_nxt_s   = crc_upd_s;
                    count_nxt_s = CNT_W'(1);
                    state_nxt_s = ST_DATA;
                end else if (accept_s) begin
                    // Latch the check result and launch byte 0 on the next cycle.
                    err_nxt_s      = (bus.datain != crc_r);
                    count_nxt_s    = CNT_W'(0);
                    out_cnt_nxt_s  = 2'd0;
                    pushout_nxt_s  = 1'b1;
                    startout_nxt_s = 1'b1;
                    dataout_nxt_s  = buf_r[0];
                    state_nxt_s    = ST_OUT;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
            ST_OUT: begin
                // out_cnt_r is the index of the byte currently on dataout.
                if (out_cnt_r == LAST_OUT_IDX) begin
                    out_cnt_nxt_s = 2'd0;
                    crc_nxt_s     = CRC_INIT;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    out_cnt_nxt_s = out_cnt_r + 2'd1;
                    pushout_nxt_s = 1'b1;
                    dataout_nxt_s = buf_r[out_cnt_nxt_s];
                    if (out_cnt_nxt_s == LAST_OUT_IDX) begin
                        endout_nxt_s = 1'b1;
                        crcerr_nxt_s = err_r;
                    end else begin
                        endout_nxt_s = 1'b0;
                        crcerr_nxt_s = 1'b0;
                    end
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        ready_nxt_s = (state_nxt_s != ST_OUT);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame datapath: byte buffer, running CRC, counters and check result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r   <= CNT_W'(0);
            crc_r     <= CRC_INIT;
            err_r     <= 1'b0;
            out_cnt_r <= 2'd0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else begin
            count_r   <= count_nxt_s;
            crc_r     <= crc_nxt_s;
            err_r     <= err_nxt_s;
            out_cnt_r <= out_cnt_nxt_s;
            if (buf_we_s) begin
                buf_r[buf_idx_s] <= bus.datain;
            end
        end
    end

    // Registered bus outputs; ready comes up as 1 straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r    <= 1'b1;
            pushout_r  <= 1'b0;
            startout_r <= 1'b0;
            endout_r   <= 1'b0;
            crcerr_r   <= 1'b0;
            dataout_r  <= 8'h00;
        end else begin
            ready_r    <= ready_nxt_s;
            pushout_r  <= pushout_nxt_s;
            startout_r <= startout_nxt_s;
            endout_r   <= endout_nxt_s;
            crcerr_r   <= crcerr_nxt_s;
            dataout_r  <= dataout_nxt_s;
        end
    end

    assign bus.ready    = ready_r;
    assign bus.pushout  = pushout_r;
    assign bus.startout = startout_r;
    assign bus.endout   = endout_r;
    assign bus.crcerr   = crcerr_r;
    assign bus.dataout  = dataout_r;

endmodule

// File: doc/crc_decoder.md
CRC_DECODER -- requirements
Module: crc_decoder

Interface
REQ-001 The block SHALL use one clock: clk, input, 1 bit, all state on its rising edge.
REQ-002 The block SHALL have reset, input, 1 bit, asynchronous and active-low: assertion at 0 takes effect immediately; release is synchronous to clk.
REQ-003 The block SHALL have pushin, input, 1 bit: datain is valid this cycle.
REQ-004 The block SHALL have startin, input, 1 bit: qualifies pushin as the first byte of a frame.
REQ-005 The block SHALL have datain, input, 8 bits: frame byte, MSB first into the CRC.
REQ-006 The block SHALL have ready, output, 1 bit: the block accepts pushin this cycle; upstream holds bytes while ready=0.
REQ-007 The block SHALL have pushout, output, 1 bit: dataout is valid.
REQ-008 The block SHALL have startout, output, 1 bit: first payload byte of an output frame.
REQ-009 The block SHALL have endout, output, 1 bit: last payload byte of an output frame.
REQ-010 The block SHALL have dataout, output, 8 bits: payload byte.
REQ-011 The block SHALL have crcerr, output, 1 bit: valid only with endout; 1 = received CRC mismatch.

Function
REQ-012 Frame format SHALL be 4 payload bytes followed by 1 CRC byte; an input byte is accepted only when pushin=1 and ready=1.
REQ-013 CRC SHALL be CRC-8, poly 0x07, init 0x00, non-reflected, no final XOR, computed over the 4 payload bytes only.
REQ-014 FSM states SHALL be IDLE, DATA, CHK, OUT.
REQ-015 In IDLE, ready=1; an accepted byte with startin=1 SHALL be stored as byte 0, CRC updated from init, count=1, next state DATA; an accepted byte with startin=0 SHALL be dropped.
REQ-016 In DATA, ready=1; an accepted byte with startin=0 SHALL be stored at index count and count incremented, entering CHK after byte 3.
REQ-017 In DATA or CHK, an accepted byte with startin=1 SHALL discard the partial frame and restart as byte 0 (resync), staying in or returning to DATA.
REQ-018 In CHK, ready=1; an accepted byte with startin=0 SHALL be compared with the running CRC, the result latched, next state OUT.
REQ-019 In OUT, ready=0 and the block SHALL emit bytes 0..3 on 4 consecutive cycles with pushout=1, startout=1 on byte 0 only, endout=1 and crcerr valid on byte 3 only, then return to IDLE.
REQ-020 First output byte SHALL appear the cycle after the CRC byte is accepted; a new frame can be accepted the cycle after endout.
REQ-021 Outside OUT, pushout, startout, endout and crcerr SHALL be 0; dataout SHALL hold its last value.
REQ-022 Frames with bad CRC SHALL still be forwarded in full, flagged only by crcerr.

Reset
REQ-023 On reset=0, state SHALL be IDLE, count=0, CRC=0x00, buffer=0, and pushout, startout, endout, crcerr and dataout SHALL be 0; ready SHALL be 1 after release.
REQ-024 Reset mid-frame or mid-OUT SHALL abort the frame with no further output bytes.

Structure
REQ-025 Package crc_pkg SHALL hold CRC_POLY=8'h07, CRC_INIT=8'h00, FRAME_BYTES=4 and the FSM state enum.
REQ-026 Sub-module crc8_update SHALL be the combinational function (crc_in, byte) -> crc_out, shared with the encoder side.

Verification
REQ-027 Frame 00,00,00,01 (start on first) + CRC 07 -> out 00,00,00,01 on 4 cycles, startout on byte 0, endout on byte 3, crcerr=0.
REQ-028 Frame 00,00,00,80 + CRC 89 -> crcerr=0; same frame + CRC 88 -> full frame out, crcerr=1.
REQ-029 Bytes AA,BB with startin=0 in IDLE, then frame 00,00,00,02 + 0E -> AA/BB dropped, one clean frame out.
REQ-030 Start 11,22, then startin=1 on 00 followed by 00,00,01 + 07 -> resync, single frame 00,00,00,01 out, crcerr=0.
REQ-031 reset=0 during OUT byte 1 -> outputs 0 immediately, no further pushout, next frame decodes normally.
REQ-032 pushin held high during OUT -> ready=0 for exactly 4 cycles, no byte accepted, back-to-back frames pass with no loss.
